delay_line_var: RTL and testbench

// Runtime-programmable N-bit delay line, 0..MAX_DELAY clock-enabled stages, with output-valid tracking.

---
 rtl/delay_line_var.sv | 154 +++++++++++++++
 tb/tb_delay_line_var.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/delay_line_var.sv
// ---------------------------------------------------------------------------
// delay_line_var
//
// Runtime-programmable delay line for N-bit samples. A circular buffer of
// MAX_DELAY slots, addressed by a write pointer, stands in for a chain of
// clock-enabled registers. The active delay d is re-registered from the
// `delay` port on every clock edge, whether or not ce is high.
//
// Behaviour by active delay:
//   d >= 1 : the block behaves like a chain of d ce-gated registers.
//            A fill counter tracks how many samples have been accepted since
//            the last flush. ovalid rises once that count reaches d.
//   d == 0 : odata and ovalid pass straight through combinationally.
//            Buffer writes still continue in this mode.
//
// Any change of d flushes the line. Stored samples are kept in the buffer,
// but none of them is shown until the line has refilled under the new d.
// A request above MAX_DELAY is clamped to MAX_DELAY and sets delay_err.
// delay_err is sticky and only rst clears it.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   ce         in   1   clock enable; one sample is accepted per enabled edge
//   delay      in   DW  requested delay in ce-events, 0..MAX_DELAY
//   idata      in   N   input sample
//   odata      out  N   delayed sample (0 while not valid or in reset)
//   ovalid     out  1   odata is a real sample delayed by the active delay
//   delay_err  out  1   sticky out-of-range delay request flag
// ---------------------------------------------------------------------------
module delay_line_var #(
  parameter int N         = 8,
  parameter int MAX_DELAY = 16,
  parameter int DW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [DW-1:0] delay,
  input  logic [N-1:0]  idata,
  output logic [N-1:0]  odata,
  output logic          ovalid,
  output logic          delay_err
);

  localparam int            PW       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DW-1:0] MAX_D    = DW'(MAX_DELAY);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_DELAY - 1);
  localparam logic [DW:0]   MAX_DX   = (DW+1)'(MAX_DELAY);

  // State
  logic [N-1:0]  r_mem [MAX_DELAY];
  logic [PW-1:0] r_ptr;     // slot written by the next enabled edge
  logic [DW-1:0] r_fill;    // samples accepted since the last flush, saturates at d
  logic [DW-1:0] r_d;       // active delay
  logic [N-1:0]  r_odata;
  logic          r_ovalid;
  logic          r_err;

  // Requested delay, clamped to the legal range
  logic          w_req_err;
  logic [DW-1:0] w_new_d;
  logic          w_flush;
  logic          w_bypass;

  assign w_req_err = (delay > MAX_D);
  assign w_new_d   = w_req_err ? MAX_D : delay;
  assign w_flush   = (w_new_d != r_d);
  assign w_bypass  = (r_d == '0);

  // Read address = ptr - (d-1) modulo MAX_DELAY, computed under the new d.
  // This is correct because a delay change and a ce on the same edge belong
  // to the new d. Adding MAX_DELAY before the subtraction keeps the sum
  // non-negative, so a single conditional subtract finishes the modulo.
  logic [DW-1:0] w_dm1;
  logic [DW:0]   w_rd_sum;
  logic [DW:0]   w_rd_wrap;
  logic [PW-1:0] w_rd_addr;
  logic [N-1:0]  w_sample;

  assign w_dm1     = (w_new_d == '0) ? '0 : w_new_d - 1'b1;
  assign w_rd_sum  = (DW+1)'(r_ptr) + MAX_DX - (DW+1)'(w_dm1);
  assign w_rd_wrap = (w_rd_sum >= MAX_DX) ? w_rd_sum - MAX_DX : w_rd_sum;
  assign w_rd_addr = PW'(w_rd_wrap);

  // At d=1 the read slot is the one being written on this same edge.
  // The buffer still holds the old value there, so forward idata instead.
  assign w_sample  = (w_new_d == DW'(1)) ? idata : r_mem[w_rd_addr];

  // Next fill count and next valid flag
  logic [DW-1:0] w_fill_next;
  logic          w_valid_next;
  logic          w_out_upd;

  // NOTE: every signal written in an always_comb gets a default value first.
  // This prevents an incomplete if/else from inferring a latch.
  always_comb begin
    w_fill_next = r_fill;
    if (w_new_d == '0) begin
      w_fill_next = '0;
    end else if (w_flush) begin
      // A sample accepted on the flush edge is the first one under the new d
      w_fill_next = ce ? DW'(1) : '0;
    end else if (ce) begin
      w_fill_next = (r_fill >= w_new_d) ? w_new_d : r_fill + 1'b1;
    end
  end

  // A flush with ce=0 must still clear the output, so either event updates it
  assign w_out_upd    = w_flush | ce;
  assign w_valid_next = (w_new_d != '0) && (w_fill_next >= w_new_d);

  // NOTE: sequential state is written only with non-blocking assignments.
  // This way every register samples values from before the edge,
  // whatever order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_fill   <= '0;
      r_d      <= '0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_d    <= w_new_d;
      r_fill <= w_fill_next;
      if (w_req_err) begin
        r_err <= 1'b1;
      end
      if (ce) begin
        r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
      end
      if (w_out_upd) begin
        r_ovalid <= w_valid_next;
        r_odata  <= w_valid_next ? w_sample : '0;
      end
    end
  end

  // NOTE: the sample buffer is deliberately left without a reset.
  // The fill counter guarantees that no slot is read before it has been
  // written since the last flush, so clearing the array would only cost area.
  always_ff @(posedge clk) begin
    if (ce && !rst) begin
      r_mem[r_ptr] <= idata;
    end
  end

  // Bypass and reset gating are combinational so they act in the same cycle
  assign odata     = rst ? '0 : (w_bypass ? idata : r_odata);
  assign ovalid    = !rst && (w_bypass || r_ovalid);
  assign delay_err = r_err;

endmodule

// File: tb/tb_delay_line_var.sv
// ---------------------------------------------------------------------------
// tb_delay_line_var
//
// The reference model keeps the list of samples accepted since the last
// flush. The delayed output is simply the entry d places from the end of
// that list. Inputs are driven on the falling edge. Outputs are compared 1
// time unit later, so combinational bypass and registered values can both
// be checked against the model state and the current inputs.
// ---------------------------------------------------------------------------
module tb_delay_line_var;

  localparam int N         = 8;
  localparam int MAX_DELAY = 16;
  localparam int DW        = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [DW-1:0] delay;
  logic [N-1:0]  idata;
  logic [N-1:0]  odata;
  logic          ovalid;
  logic          delay_err;

  always #5 clk = ~clk;

  delay_line_var #(.N(N), .MAX_DELAY(MAX_DELAY), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .delay     (delay),
    .idata     (idata),
    .odata     (odata),
    .ovalid    (ovalid),
    .delay_err (delay_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state, as it stands after the most recent clock edge
  int m_hist[$];     // samples accepted since the last flush, oldest first
  int m_d      = 0;
  bit m_err    = 0;
  int m_odata  = 0;
  bit m_ovalid = 0;

  task automatic model_edge(input bit r, input bit c, input int dl, input int din);
    int  nd;
    bit  flush;
    if (r) begin
      m_hist.delete();
      m_d = 0; m_err = 0; m_odata = 0; m_ovalid = 0;
      return;
    end
    nd = (dl > MAX_DELAY) ? MAX_DELAY : dl;
    if (dl > MAX_DELAY) m_err = 1;
    flush = (nd != m_d);
    if (flush) m_hist.delete();
    if (c) begin
      m_hist.push_back(din);
      if (m_hist.size() > MAX_DELAY) void'(m_hist.pop_front());
    end
    if (nd == 0) begin
      m_odata = 0; m_ovalid = 0;
    end else if (c || flush) begin
      if (m_hist.size() >= nd) begin
        m_odata  = m_hist[m_hist.size() - nd];
        m_ovalid = 1;
      end else begin
        m_odata  = 0;
        m_ovalid = 0;
      end
    end
    m_d = nd;
  endtask

  // One cycle: drive on the falling edge, check, then advance the model on the rising edge
  task automatic drive(input bit r, input bit c, input int dl, input int din);
    int exp_data;
    bit exp_valid;
    @(negedge clk);
    rst   = r;
    ce    = c;
    delay = DW'(dl);
    idata = N'(din);
    #1;
    if (r) begin
      exp_data = 0; exp_valid = 0;
    end else if (m_d == 0) begin
      exp_data = din & ((1 << N) - 1); exp_valid = 1;
    end else begin
      exp_data = m_odata; exp_valid = m_ovalid;
    end
    check("odata", 32'(odata), 32'(exp_data));
    check("ovalid", 32'(ovalid), 32'(exp_valid));
    check("delay_err", 32'(delay_err), 32'(m_err));
    @(posedge clk);
    model_edge(r, c, dl, din & ((1 << N) - 1));
  endtask

  initial begin
    int a;
    int b;
    int cur_d;

    rst = 1'b1; ce = 1'b0; delay = '0; idata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_odata", 32'(odata), 32'd0);
    check("reset_ovalid", 32'(ovalid), 32'd0);
    check("reset_err", 32'(delay_err), 32'd0);

    // d=1, consecutive samples come out one edge later
    for (int i = 1; i <= 3; i++) drive(0, 1, 1, i);
    #1;
    check("t1_odata", 32'(odata), 32'd3);
    check("t1_ovalid", 32'(ovalid), 32'd1);

    // d=4: the first sample 10 appears at the 4th edge. After 8 edges odata is 14.
    for (int i = 0; i < 8; i++) drive(0, 1, 4, 10 + i);
    #1;
    check("t2_odata", 32'(odata), 32'd14);

    // d=3 with ce toggling
    for (int i = 0; i < 16; i++) drive(0, (i % 2) == 0, 3, $urandom_range(255));

    // running at d=5, then switch to 2 together with ce
    for (int i = 0; i < 8; i++) drive(0, 1, 5, $urandom_range(255));
    a = $urandom_range(255);
    b = $urandom_range(255);
    drive(0, 1, 2, a);
    #1;
    check("t4_flush_odata", 32'(odata), 32'd0);
    check("t4_flush_ovalid", 32'(ovalid), 32'd0);
    drive(0, 1, 2, b);
    #1;
    check("t4_refill_odata", 32'(odata), 32'(a));
    check("t4_refill_ovalid", 32'(ovalid), 32'd1);

    // out-of-range request: clamps to MAX_DELAY and the error flag is sticky
    for (int i = 0; i < 20; i++) drive(0, 1, 20, $urandom_range(255));
    #1;
    check("t5_err_set", 32'(delay_err), 32'd1);
    for (int i = 0; i < 6; i++) drive(0, 1, 3, $urandom_range(255));
    #1;
    check("t5_err_sticky", 32'(delay_err), 32'd1);
    drive(1, 1, 3, 0);
    #1;
    check("t5_err_cleared", 32'(delay_err), 32'd0);

    // bypass, then a reset mid-stream at d=8
    for (int i = 0; i < 6; i++) drive(0, $urandom_range(1), 0, $urandom_range(255));
    for (int i = 0; i < 12; i++) drive(0, 1, 8, $urandom_range(255));
    drive(1, 1, 8, $urandom_range(255));
    for (int i = 0; i < 7; i++) drive(0, 1, 8, $urandom_range(255));
    #1;
    check("t6_not_yet_valid", 32'(ovalid), 32'd0);
    drive(0, 1, 8, $urandom_range(255));
    #1;
    check("t6_refilled", 32'(ovalid), 32'd1);

    // randomized run: occasional delay changes, out-of-range requests and resets
    cur_d = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) cur_d = $urandom_range(20);
      drive($urandom_range(199) == 0, $urandom_range(3) != 0, cur_d, $urandom_range(255));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
